// File: rtl/pool2_tx.sv
// 2x2 max-pool stage between conv2 and FC: streams a raster feature map in,
// emits the pooled map in raster order through a one-deep output register.
module pool2_tx #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int IMG_W         = 8,
  parameter int IMG_H         = 8
) (
  input  logic                     POOL2_Clock,
  input  logic                     POOL2_Reset,
  input  logic                     POOL2_Start,
  input  logic                     POOL2_InValid,
  input  logic [DATAWIDTH_BUS-1:0] POOL2_InBUS,
  output logic                     POOL2_InReady,
  output logic [DATAWIDTH_BUS-1:0] POOL2_OutBUS,
  output logic                     POOL2_OutValid,
  input  logic                     POOL2_OutReady,
  output logic                     POOL2_Busy,
  output logic                     POOL2_Done,
  output logic [1:0]               dbg_state_o
);

  // Handshake: a beat moves on a bus in any cycle where its valid and ready
  // are both high at the rising edge; valid never waits on ready, and an
  // offered output holds its data until taken.

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int LBN = IMG_W / 2;
  localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic [DATAWIDTH_BUS-1:0] pair_q;
  logic [DATAWIDTH_BUS-1:0] lb_q [LBN];
  logic [DATAWIDTH_BUS-1:0] out_bus_q, out_bus_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, done_q;

  logic                     in_ready;
  logic                     in_fire;
  logic                     out_fire;
  logic                     col_last;
  logic                     row_last;
  logic                     load;
  logic [LBW-1:0]           lb_idx;
  logic [DATAWIDTH_BUS-1:0] pair_max;
  logic [DATAWIDTH_BUS-1:0] lb_rd;
  logic [DATAWIDTH_BUS-1:0] win_max;

  // Input stalls whenever the output register is full and not draining.
  assign in_ready = (state_q == S_RUN) && (!out_valid_q || POOL2_OutReady);
  assign in_fire  = POOL2_InValid && in_ready;
  assign out_fire = out_valid_q && POOL2_OutReady;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign lb_idx   = LBW'(col_q >> 1);
  assign lb_rd    = lb_q[lb_idx];
  assign pair_max = (POOL2_InBUS > pair_q) ? POOL2_InBUS : pair_q;
  assign win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
  assign load     = in_fire && col_q[0] && row_q[0];

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_bus_d   = out_bus_q;

    case (state_q)
      S_IDLE:  if (POOL2_Start) state_d = S_RUN;
      S_RUN:   if (in_fire && col_last && row_last) state_d = S_DRAIN;
      S_DRAIN: if (!out_valid_q || out_fire) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (in_fire) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // A new result may land in the same cycle the previous one is taken.
    if (load) begin
      out_valid_d = 1'b1;
      out_bus_d   = win_max;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge POOL2_Clock) begin
    if (POOL2_Reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_bus_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_bus_q   <= out_bus_d;
      busy_q      <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q      <= (state_d == S_DONE);
    end
  end

  // Pair and line-buffer storage is always rewritten before it is read in a frame.
  always_ff @(posedge POOL2_Clock) begin
    if (in_fire && !col_q[0]) pair_q <= POOL2_InBUS;
    if (in_fire && col_q[0] && !row_q[0]) lb_q[lb_idx] <= pair_max;
  end

  assign POOL2_InReady  = in_ready;
  assign POOL2_OutBUS   = out_bus_q;
  assign POOL2_OutValid = out_valid_q;
  assign POOL2_Busy     = busy_q;
  assign POOL2_Done     = done_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pool2_tx.sv
// Directed bench for pool2_tx: a 4x4 instance for hand-computed frames and an
// 8x8 instance for a gapped frame checked against a max-pool model.
module tb_pool2_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_bus;
  logic       out_ready;

  logic       ir4, ov4, busy4, done4, ir8, ov8, busy8, done8;
  logic [7:0] ob4, ob8;
  logic [1:0] st4, st8;

  logic       sel;
  logic       s_ir, s_ov, s_busy, s_done;
  logic [7:0] s_ob;
  logic [1:0] s_st;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] pix [64];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  pool2_tx #(.DATAWIDTH_BUS(8), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .POOL2_Clock(clk), .POOL2_Reset(rst), .POOL2_Start(start),
    .POOL2_InValid(in_valid), .POOL2_InBUS(in_bus), .POOL2_InReady(ir4),
    .POOL2_OutBUS(ob4), .POOL2_OutValid(ov4), .POOL2_OutReady(out_ready),
    .POOL2_Busy(busy4), .POOL2_Done(done4), .dbg_state_o(st4)
  );

  pool2_tx #(.DATAWIDTH_BUS(8), .IMG_W(8), .IMG_H(8)) u_dut8 (
    .POOL2_Clock(clk), .POOL2_Reset(rst), .POOL2_Start(start),
    .POOL2_InValid(in_valid), .POOL2_InBUS(in_bus), .POOL2_InReady(ir8),
    .POOL2_OutBUS(ob8), .POOL2_OutValid(ov8), .POOL2_OutReady(out_ready),
    .POOL2_Busy(busy8), .POOL2_Done(done8), .dbg_state_o(st8)
  );

  assign s_ir   = sel ? ir8   : ir4;
  assign s_ov   = sel ? ov8   : ov4;
  assign s_ob   = sel ? ob8   : ob4;
  assign s_busy = sel ? busy8 : busy4;
  assign s_done = sel ? done8 : done4;
  assign s_st   = sel ? st8   : st4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_state",     32'(s_st),   32'd0);
    check("rst_out_valid", 32'(s_ov),   32'd0);
    check("rst_out_bus",   32'(s_ob),   32'd0);
    check("rst_in_ready",  32'(s_ir),   32'd0);
    check("rst_busy",      32'(s_busy), 32'd0);
    check("rst_done",      32'(s_done), 32'd0);
    rst = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_busy", 32'(s_busy), 32'd1);
  endtask

  function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? a : b;
  endfunction

  // Reference 2x2 max-pool over pix[] for a w x h frame.
  task automatic push_model(input int w, input int h);
    for (int r = 0; r < h / 2; r++)
      for (int c = 0; c < w / 2; c++)
        exp_q.push_back(max2(max2(pix[2*r*w + 2*c], pix[2*r*w + 2*c + 1]),
                             max2(pix[(2*r+1)*w + 2*c], pix[(2*r+1)*w + 2*c + 1])));
  endtask

  task automatic run_frame(input int n, input int vgap, input int rgap, input int stall_at,
                           input int start_at, input int abort_at, input int n_out);
    int         idx = 0;
    int         outs = 0;
    int         dones = 0;
    int         cyc = 0;
    bit         stalled = 1'b0;
    bit         restarted = 1'b0;
    logic [7:0] held;
    logic [31:0] e;
    do_start();
    while (cyc < 3000) begin
      @(negedge clk);
      if (abort_at >= 0 && idx >= abort_at) begin
        in_valid = 1'b0; out_ready = 1'b0;
        return;
      end
      in_valid  = (idx < n) && ($urandom_range(0, 99) >= vgap);
      in_bus    = (idx < n) ? pix[idx] : 8'd0;
      out_ready = ($urandom_range(0, 99) >= rgap);
      start     = (start_at >= 0 && idx == start_at && !restarted);
      if (start) restarted = 1'b1;
      #1;
      if (stall_at >= 0 && !stalled && s_ov && outs == stall_at) begin
        stalled = 1'b1; out_ready = 1'b0; held = s_ob;
        for (int k = 0; k < 10; k++) begin
          #1;
          check("stall_in_ready",  32'(s_ir), 32'd0);
          check("stall_out_valid", 32'(s_ov), 32'd1);
          check("stall_out_bus",   32'(s_ob), 32'(held));
          @(negedge clk);
        end
        continue;
      end
      if (s_done) dones++;
      if (s_ov && out_ready) begin
        e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
        check("out_data", 32'(s_ob), e);
        outs++;
      end
      if (in_valid && s_ir) idx++;
      cyc++;
      if (dones > 0 && !s_done) break;
    end
    in_valid = 1'b0; start = 1'b0;
    check("out_count",   32'(outs),         32'(n_out));
    check("exp_left",    32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(dones),        32'd1);
    check("post_busy",   32'(s_busy),       32'd0);
    check("post_state",  32'(s_st),         32'd0);
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) pix[i] = 8'(i);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bus = '0; out_ready = 1'b0;
    sel = 1'b0;
    exp_q.delete();
    do_reset();

    // Ramp 0..15, sink always ready.
    fill_ramp(16);
    exp_q.push_back(8'd5); exp_q.push_back(8'd7);
    exp_q.push_back(8'd13); exp_q.push_back(8'd15);
    run_frame(16, 0, 0, -1, -1, -1, 4);

    // Dominant corner, all-equal window, and extreme values.
    pix[0]  = 8'd200; pix[1]  = 8'd3; pix[2]  = 8'd9; pix[3]  = 8'd9;
    pix[4]  = 8'd3;   pix[5]  = 8'd3; pix[6]  = 8'd9; pix[7]  = 8'd9;
    pix[8]  = 8'd255; pix[9]  = 8'd0; pix[10] = 8'd0; pix[11] = 8'd0;
    pix[12] = 8'd0;   pix[13] = 8'd0; pix[14] = 8'd0; pix[15] = 8'd0;
    exp_q.push_back(8'd200); exp_q.push_back(8'd9);
    exp_q.push_back(8'd255); exp_q.push_back(8'd0);
    run_frame(16, 0, 0, -1, -1, -1, 4);

    // Sink stalls 10 cycles on the first output.
    fill_ramp(16);
    exp_q.push_back(8'd5); exp_q.push_back(8'd7);
    exp_q.push_back(8'd13); exp_q.push_back(8'd15);
    run_frame(16, 0, 0, 0, -1, -1, 4);

    // Reset after 6 inputs, then a clean frame.
    pix[0] = 8'd250; pix[1] = 8'd251; pix[4] = 8'd252; pix[5] = 8'd253;
    run_frame(16, 0, 0, -1, -1, 6, 0);
    do_reset();
    fill_ramp(16);
    exp_q.push_back(8'd5); exp_q.push_back(8'd7);
    exp_q.push_back(8'd13); exp_q.push_back(8'd15);
    run_frame(16, 0, 0, -1, -1, -1, 4);

    // Start pulsed mid-frame.
    exp_q.push_back(8'd5); exp_q.push_back(8'd7);
    exp_q.push_back(8'd13); exp_q.push_back(8'd15);
    run_frame(16, 0, 0, -1, 5, -1, 4);

    // 8x8 frame with random data and 50% gaps on both sides.
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 64; i++) pix[i] = 8'($urandom_range(0, 255));
    pix[9] = 8'd255; pix[54] = 8'd0;
    push_model(8, 8);
    run_frame(64, 50, 50, -1, -1, -1, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pool2_tx.md
POOL2_TX -- requirements
Module: pool2_tx

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 8, pixel width on both buses.
REQ-002 SHALL have parameter IMG_W, default 8, input feature-map columns (even, >=2).
REQ-003 SHALL have parameter IMG_H, default 8, input feature-map rows (even, >=2).
REQ-004 SHALL have port POOL2_Clock  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port POOL2_Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port POOL2_Start  input  1  one-cycle pulse, begins one frame.
REQ-007 SHALL have port POOL2_InValid  input  1  input pixel valid from conv2 stage.
REQ-008 SHALL have port POOL2_InBUS  input  DATAWIDTH_BUS  unsigned pixel, raster order.
REQ-009 SHALL have port POOL2_InReady  output  1  block accepts input pixel this cycle.
REQ-010 SHALL have port POOL2_OutBUS  output  DATAWIDTH_BUS  pooled pixel to FC (drives FC_InBUS).
REQ-011 SHALL have port POOL2_OutValid  output  1  pooled pixel valid (drives FC_Enable).
REQ-012 SHALL have port POOL2_OutReady  input  1  FC accepts pooled pixel this cycle.
REQ-013 SHALL have port POOL2_Busy  output  1  frame in progress.
REQ-014 SHALL have port POOL2_Done  output  1  one-cycle pulse after last pooled pixel transferred.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE -> RUN on POOL2_Start; Start ignored outside IDLE.
REQ-017 RUN -> DRAIN when the last input pixel (row IMG_H-1, col IMG_W-1) is accepted.
REQ-018 DRAIN -> DONE when the output register is empty or transfers that cycle; DONE -> IDLE unconditionally next cycle.
REQ-019 Input transfer SHALL occur when POOL2_InValid && POOL2_InReady; output transfer when POOL2_OutValid && POOL2_OutReady.
REQ-020 POOL2_InReady SHALL be 1 only in RUN and only when (!POOL2_OutValid || POOL2_OutReady).
REQ-021 Column counter SHALL count 0..IMG_W-1 and wrap to 0 incrementing row counter 0..IMG_H-1, advancing only on input transfer.
REQ-022 Even column pixel SHALL be held in a pair register; odd column pixel SHALL form pairmax = max(pair register, current pixel), unsigned compare, ties keep either (equal value).
REQ-023 On even rows pairmax SHALL be written to line buffer entry col/2 (IMG_W/2 entries x DATAWIDTH_BUS).
REQ-024 On odd rows, odd column, max(line buffer[col/2], pairmax) SHALL load the output register and set POOL2_OutValid next cycle (latency 1 cycle from accepting the 4th window pixel).
REQ-025 POOL2_OutValid SHALL remain high and POOL2_OutBUS stable until output transfer; OutValid clears on transfer unless a new result loads in the same cycle.
REQ-026 Output order SHALL be raster over (IMG_H/2) x (IMG_W/2) pooled map; exactly IMG_W*IMG_H/4 outputs per frame.
REQ-027 POOL2_Busy SHALL be 1 in RUN and DRAIN, else 0.
REQ-028 POOL2_Done SHALL be 1 only in DONE.
REQ-029 Width rule: no arithmetic widening; outputs SHALL equal one of the four window inputs bit-exactly.

Reset
REQ-030 While POOL2_Reset is 1 at a clock edge: state IDLE, counters 0, POOL2_OutValid 0, POOL2_OutBUS 0, POOL2_InReady 0, POOL2_Busy 0, POOL2_Done 0.
REQ-031 Reset SHALL override all other inputs, including mid-frame; partial frame data discarded, no output emitted.
REQ-032 Line buffer and pair register contents need no reset; they SHALL never reach POOL2_OutBUS before being written in the current frame.

Verification
REQ-033 IMG_W=IMG_H=4, inputs 0..15 raster, OutReady=1 -> outputs 5,7,13,15 in order, Done pulse once, Busy low after.
REQ-034 Window {200,3,3,3} first, {9,9,9,9} second (row0/1) -> outputs 200 then 9; values 255 and 0 pass unaltered.
REQ-035 OutReady held 0 for 10 cycles with OutValid=1 -> InReady=0, OutBUS stable, no input lost; release -> sequence identical to REQ-033.
REQ-036 Random InValid gaps (50%) and OutReady gaps (50%) on 8x8 frame -> 16 outputs matching reference max-pool model.
REQ-037 Reset asserted after 6 inputs, then Start with fresh frame -> no stale output; results equal clean-frame run.
REQ-038 Start pulsed during RUN -> ignored; frame completes with exactly IMG_W*IMG_H/4 outputs and one Done.
